// File: rtl/display_rotator_n.sv
// N-channel 7-segment source rotator: cycles through enabled channels with a fixed dwell,
// supporting hold and manual advance. All outputs are registered.
module display_rotator_n #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 16,
  parameter int DWELL_CYCLES = 200000000,
  localparam int CH_W        = $clog2(NUM_CH),
  localparam int CNT_W       = $clog2(DWELL_CYCLES)
) (
  input  logic                     clk100Mhz,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH-1:0]        dp_mask,
  input  logic                     hold,
  input  logic                     next_pulse,
  output logic [DATA_W-1:0]        display_value,
  output logic                     dp,
  output logic [CH_W-1:0]          ch_sel,
  output logic                     blank,
  output logic                     rotate_strobe
);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   display_value_q, display_value_d;
  logic                dp_q, dp_d;
  logic                blank_q, blank_d;
  logic                rotate_strobe_q, rotate_strobe_d;

  logic [DATA_W-1:0]   ch_word [NUM_CH];
  logic [CH_W-1:0]     lowest_idx;
  logic [CH_W-1:0]     next_idx;
  logic                next_found;
  logic [CH_W:0]       sum;
  logic [CH_W-1:0]     cand;
  logic                advance;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_word[k] = ch_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_enable[i]) lowest_idx = CH_W'(i);
    end
  end

  // Circular search starting just past the current channel; offset NUM_CH lands back on
  // ch_sel itself, so a lone enabled channel keeps its index.
  always_comb begin
    next_idx   = ch_sel_q;
    next_found = 1'b0;
    sum        = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      sum = {1'b0, ch_sel_q} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      cand = sum[CH_W-1:0];
      if (!next_found && ch_enable[cand]) begin
        next_idx   = cand;
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    ch_sel_d        = ch_sel_q;
    cnt_d           = cnt_q;
    display_value_d = '0;
    dp_d            = 1'b0;
    blank_d         = 1'b1;
    advance         = 1'b0;

    case (state_q)
      S_BLANK: begin
        cnt_d = '0;
        if (|ch_enable) begin
          ch_sel_d = lowest_idx;
          state_d  = S_SHOW;
        end
      end
      S_SHOW: begin
        display_value_d = ch_word[ch_sel_q];
        dp_d            = dp_mask[ch_sel_q];
        blank_d         = 1'b0;
        advance         = (!hold && (cnt_q == CNT_MAX)) || next_pulse || !ch_enable[ch_sel_q];
        if (ch_enable == '0) begin
          state_d = S_BLANK;
          cnt_d   = '0;
        end else if (advance) begin
          ch_sel_d = next_idx;
          cnt_d    = '0;
        end else if (!hold) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_BLANK;
    endcase

    rotate_strobe_d = (ch_sel_d != ch_sel_q);
  end

  always_ff @(posedge clk100Mhz or posedge rst) begin
    if (rst) begin
      state_q         <= S_BLANK;
      ch_sel_q        <= '0;
      cnt_q           <= '0;
      display_value_q <= '0;
      dp_q            <= 1'b0;
      blank_q         <= 1'b1;
      rotate_strobe_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ch_sel_q        <= ch_sel_d;
      cnt_q           <= cnt_d;
      display_value_q <= display_value_d;
      dp_q            <= dp_d;
      blank_q         <= blank_d;
      rotate_strobe_q <= rotate_strobe_d;
    end
  end

  assign display_value = display_value_q;
  assign dp            = dp_q;
  assign ch_sel        = ch_sel_q;
  assign blank         = blank_q;
  assign rotate_strobe = rotate_strobe_q;

endmodule

// File: tb/tb_display_rotator_n.sv
// Directed bench for display_rotator_n (4 channels, 4-cycle dwell); expected output tuples
// are queued alongside the stimulus and popped one per clock.
module tb_display_rotator_n;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int DWELL  = 4;

  logic                     clk100Mhz = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic [NUM_CH-1:0]        ch_enable = '0;
  logic [NUM_CH-1:0]        dp_mask = '0;
  logic                     hold = 1'b0;
  logic                     next_pulse = 1'b0;
  logic [DATA_W-1:0]        display_value;
  logic                     dp;
  logic [1:0]               ch_sel;
  logic                     blank;
  logic                     rotate_strobe;

  display_rotator_n #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .DWELL_CYCLES(DWELL)
  ) dut (
    .clk100Mhz(clk100Mhz),
    .rst(rst),
    .ch_data(ch_data),
    .ch_enable(ch_enable),
    .dp_mask(dp_mask),
    .hold(hold),
    .next_pulse(next_pulse),
    .display_value(display_value),
    .dp(dp),
    .ch_sel(ch_sel),
    .blank(blank),
    .rotate_strobe(rotate_strobe)
  );

  always #5 clk100Mhz = ~clk100Mhz;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] val;
    logic        dpv;
    logic        blk;
    logic        stb;
  } exp_t;

  exp_t exp_q[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;

  function automatic logic [15:0] data_of(input int k);
    return 16'h1000 + 16'(k);
  endfunction

  task automatic push_exp(input logic [1:0] sel, input logic [15:0] val, input logic dpv,
                          input logic blk, input logic stb);
    exp_t e;
    e.sel = sel;
    e.val = val;
    e.dpv = dpv;
    e.blk = blk;
    e.stb = stb;
    exp_q.push_back(e);
  endtask

  // One full dwell on channel k: the first cycle still shows what the register held before.
  task automatic push_dwell(input int k, input logic [15:0] first_val, input logic first_dp,
                            input logic first_blank, input logic stb);
    push_exp(2'(k), first_val, first_dp, first_blank, stb);
    repeat (DWELL - 1) push_exp(2'(k), data_of(k), dp_mask[2'(k)], 1'b0, 1'b0);
  endtask

  task automatic cmp(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] want);
    n_vectors++;
    assert (obs === want) else begin
      n_miscompares++;
      $error("[TB] FAIL %s.%s: got %0h, expected %0h", tag, field, obs, want);
    end
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    cmp(tag, "ch_sel",        32'(ch_sel),        32'(e.sel));
    cmp(tag, "display_value", 32'(display_value), 32'(e.val));
    cmp(tag, "dp",            32'(dp),            32'(e.dpv));
    cmp(tag, "blank",         32'(blank),         32'(e.blk));
    cmp(tag, "rotate_strobe", 32'(rotate_strobe), 32'(e.stb));
  endtask

  task automatic run_check(input string tag);
    while (exp_q.size() > 0) begin
      @(posedge clk100Mhz);
      #1;
      check_output(tag);
    end
  endtask

  // Asserts reset between clock edges, checks the asynchronous response, releases after an edge.
  task automatic apply_reset(input logic [3:0] en);
    rst = 1'b1;
    ch_enable = en;
    #2;
    push_exp(2'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    check_output("reset");
    @(posedge clk100Mhz);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ch_data = {data_of(3), data_of(2), data_of(1), data_of(0)};
    dp_mask = 4'b0010;
    repeat (2) @(posedge clk100Mhz);
    #1;
    push_exp(2'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    check_output("power_on");

    // all four channels rotate, ch1 lights the decimal point
    apply_reset(4'b1111);
    push_dwell(0, 16'h0000, 1'b0, 1'b1, 1'b0);
    push_dwell(1, data_of(0), 1'b0, 1'b0, 1'b1);
    push_dwell(2, data_of(1), 1'b1, 1'b0, 1'b1);
    push_dwell(3, data_of(2), 1'b0, 1'b0, 1'b1);
    push_dwell(0, data_of(3), 1'b0, 1'b0, 1'b1);
    run_check("t1_rotate");

    // skip disabled channels and wrap, then drop the current channel mid-dwell
    apply_reset(4'b1001);
    push_dwell(0, 16'h0000, 1'b0, 1'b1, 1'b0);
    push_dwell(3, data_of(0), 1'b0, 1'b0, 1'b1);
    push_dwell(0, data_of(3), 1'b0, 1'b0, 1'b1);
    push_exp(2'd3, data_of(0), 1'b0, 1'b0, 1'b1);
    push_exp(2'd3, data_of(3), 1'b0, 1'b0, 1'b0);
    run_check("t2_skip");
    ch_enable = 4'b0001;
    push_dwell(0, data_of(3), 1'b0, 1'b0, 1'b1);
    push_exp(2'd0, data_of(0), 1'b0, 1'b0, 1'b0);
    run_check("t2_drop");

    // hold, manual advance during hold, manual advance coincident with terminal count
    apply_reset(4'b1111);
    push_exp(2'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    push_exp(2'd0, data_of(0), 1'b0, 1'b0, 1'b0);
    run_check("t3_pre");
    hold = 1'b1;
    repeat (20) push_exp(2'd0, data_of(0), 1'b0, 1'b0, 1'b0);
    run_check("t3_hold");
    next_pulse = 1'b1;
    push_exp(2'd1, data_of(0), 1'b0, 1'b0, 1'b1);
    run_check("t3_pulse_hold");
    next_pulse = 1'b0;
    repeat (3) push_exp(2'd1, data_of(1), 1'b1, 1'b0, 1'b0);
    run_check("t3_held_after");
    hold = 1'b0;
    repeat (3) push_exp(2'd1, data_of(1), 1'b1, 1'b0, 1'b0);
    run_check("t3_count");
    next_pulse = 1'b1;
    push_exp(2'd2, data_of(1), 1'b1, 1'b0, 1'b1);
    run_check("t3_coincident");
    next_pulse = 1'b0;
    repeat (3) push_exp(2'd2, data_of(2), 1'b0, 1'b0, 1'b0);
    push_exp(2'd3, data_of(2), 1'b0, 1'b0, 1'b1);
    run_check("t3_after");

    // all channels off -> blank, then wake on ch2 alone
    dp_mask = 4'b1111;
    ch_enable = 4'b0000;
    push_exp(2'd3, data_of(3), 1'b1, 1'b0, 1'b0);
    push_exp(2'd3, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_check("t4_blank");
    ch_enable = 4'b0100;
    push_exp(2'd2, 16'h0000, 1'b0, 1'b1, 1'b1);
    push_exp(2'd2, data_of(2), 1'b1, 1'b0, 1'b0);
    run_check("t4_wake");

    // a lone enabled channel never strobes across several dwell periods
    repeat (12) push_exp(2'd2, data_of(2), 1'b1, 1'b0, 1'b0);
    run_check("t5_single");

    // enabling other channels mid-dwell has no immediate effect; then reset mid-dwell
    ch_enable = 4'b1111;
    push_exp(2'd2, data_of(2), 1'b1, 1'b0, 1'b0);
    run_check("t6_pre");
    dp_mask = 4'b0010;
    apply_reset(4'b1111);
    push_dwell(0, 16'h0000, 1'b0, 1'b1, 1'b0);
    push_exp(2'd1, data_of(0), 1'b0, 1'b0, 1'b1);
    run_check("t6_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
